lsu_bus: RTL

//   Multi-cycle load/store unit between the core datapath and a valid/ready data bus.

---
 rtl/lsu_bus_if.sv | 21 ++
 rtl/lsu_bus.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/lsu_bus_if.sv
// Valid/ready data bus between the load/store unit (master) and memory (slave).
// For reads, bus_rdata is valid in the same cycle as bus_ready.
interface lsu_bus_if;
   logic        bus_valid;
   logic        bus_ready;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;

   modport master (
      output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ready, bus_rdata
   );

   modport slave (
      input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ready, bus_rdata
   );
endinterface

// File: rtl/lsu_bus.sv
// Multi-cycle load/store unit: turns one core memory instruction into one byte-lane
// aligned bus access, stalling the core until the result or an error pulse is returned.
//
// state  | meaning
// IDLE   | waiting for req_valid; stall follows req_valid, request is captured
// BUSY   | bus_valid held with stable address/lanes until bus_ready or timeout
// DONE   | one-cycle completion: rd_valid plus misalign_err / bus_err as flagged
module lsu_bus #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int TO_W           = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_ctrl,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        misalign_err,
   output logic        bus_err,
   lsu_bus_if.master   bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [31:0]     addr_q;
   logic [2:0]      ctrl_q;
   logic            we_q;
   logic [31:0]     wdata_q;
   logic [3:0]      be_q;
   logic            mis_q;
   logic            to_q;
   logic [31:0]     rd_q;
   logic [TO_W-1:0] cnt_q;

   logic            is_b, is_h, mis_d;
   logic [3:0]      be_d;
   logic [31:0]     wdata_d;
   logic [31:0]     ld_shift, ld_ext;
   logic            capture, timeout_hit;

   // Access size decode; only loads use the unsigned encodings 4/5, stores fall back to word.
   always_comb begin
      is_b    = (req_ctrl == 3'd0) || (!req_we && req_ctrl == 3'd4);
      is_h    = (req_ctrl == 3'd1) || (!req_we && req_ctrl == 3'd5);
      mis_d   = (is_h && req_addr[0]) || (!is_b && !is_h && req_addr[1:0] != 2'b00);
      be_d    = 4'b1111;
      wdata_d = req_wdata;
      if (is_b) begin
         be_d    = 4'b0001 << req_addr[1:0];
         wdata_d = {4{req_wdata[7:0]}};
      end else if (is_h) begin
         be_d    = 4'b0011 << req_addr[1:0];
         wdata_d = {2{req_wdata[15:0]}};
      end
   end

   always_comb begin
      ld_shift = bus.bus_rdata >> {addr_q[1:0], 3'b000};
      case (ctrl_q)
         3'd0:    ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
         3'd4:    ld_ext = {24'd0, ld_shift[7:0]};
         3'd1:    ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
         3'd5:    ld_ext = {16'd0, ld_shift[15:0]};
         default: ld_ext = bus.bus_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      capture     = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               capture = 1'b1;
               state_d = mis_d ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            if (bus.bus_ready) begin
               state_d = S_DONE;
            end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_W'(1)) begin
               timeout_hit = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Timeout is a down-counter loaded at capture; terminal count 1 ends the last wait cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         ctrl_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         be_q    <= '0;
         mis_q   <= 1'b0;
         to_q    <= 1'b0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         if (capture) begin
            addr_q  <= req_addr;
            ctrl_q  <= req_ctrl;
            we_q    <= req_we;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            mis_q   <= mis_d;
            to_q    <= 1'b0;
            rd_q    <= '0;
            cnt_q   <= TO_W'(TIMEOUT_CYCLES);
         end
         if (state_q == S_BUSY) begin
            if (bus.bus_ready) begin
               if (!we_q) rd_q <= ld_ext;
            end else if (TIMEOUT_CYCLES != 0) begin
               cnt_q <= cnt_q - TO_W'(1);
               if (timeout_hit) to_q <= 1'b1;
            end
         end
      end
   end

   // Bus outputs derive from the state register so reset removes bus_valid immediately.
   always_comb begin
      bus.bus_valid = (state_q == S_BUSY);
      bus.bus_we    = (state_q == S_BUSY) && we_q;
      bus.bus_addr  = (state_q == S_BUSY) ? {addr_q[31:2], 2'b00} : 32'd0;
      bus.bus_be    = (state_q == S_BUSY) ? be_q : 4'd0;
      bus.bus_wdata = (state_q == S_BUSY) ? wdata_q : 32'd0;
      stall         = ((state_q == S_IDLE) && req_valid) || (state_q == S_BUSY);
      rd_valid      = (state_q == S_DONE);
      misalign_err  = (state_q == S_DONE) && mis_q;
      bus_err       = (state_q == S_DONE) && to_q;
      rd_data       = (state_q == S_DONE) ? rd_q : 32'd0;
   end

endmodule
